// File: rtl/alu_dec_pkg.sv
// alu_dec_pkg: constants shared by the ALU decoder and the ALU.
//   WORD_LEN / ALUCTRL_LEN : instruction width and ALU control width
//   alu_ctrl_e             : ALU operation codes (110 / 111 are unused)
//   OP_* / FN_*            : MIPS opcode and R-type funct values
//   dec_t                  : decoded control fields carried through the FIFO
package alu_dec_pkg;

   localparam int WORD_LEN    = 32;
   localparam int ALUCTRL_LEN = 3;

   typedef enum logic [ALUCTRL_LEN-1:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_ADDU = 3'b010,
      ALU_AND  = 3'b011,
      ALU_OR   = 3'b100,
      ALU_SLT  = 3'b101
   } alu_ctrl_e;

   // opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef struct packed {
      alu_ctrl_e ctrl;
      logic      alu_src;
      logic      imm_sext;
      logic      reg_write;
      logic      branch;
      logic      illegal;
   } dec_t;

   // Value of the decoded fields out of reset (not an illegal marker).
   localparam dec_t DEC_RST = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/alu_dec_core.sv
// alu_dec_core: purely combinational MIPS instruction -> ALU control decode.
//   instr_i : fetched instruction word
//   dec_o   : decoded fields (ctrl, alu_src, imm_sext, reg_write, branch, illegal)
module alu_dec_core
   import alu_dec_pkg::*;
#(
   parameter int W = WORD_LEN
) (
   input  logic [W-1:0] instr_i,
   output dec_t         dec_o
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       unused_bits;

   assign op = instr_i[31:26];
   assign fn = instr_i[5:0];
   // Register/immediate fields play no part in control decode.
   assign unused_bits = ^instr_i[25:6];

   always_comb begin
      // Anything not matched below stays flagged illegal with ADD / all zero.
      dec_o         = DEC_RST;
      dec_o.illegal = 1'b1;
      unique case (op)
         OP_RTYPE: begin
            dec_o.illegal   = 1'b0;
            dec_o.reg_write = 1'b1;
            unique case (fn)
               FN_ADD:  dec_o.ctrl = ALU_ADD;
               FN_ADDU: dec_o.ctrl = ALU_ADDU;
               FN_SUB:  dec_o.ctrl = ALU_SUB;
               FN_AND:  dec_o.ctrl = ALU_AND;
               FN_OR:   dec_o.ctrl = ALU_OR;
               FN_SLT:  dec_o.ctrl = ALU_SLT;
               default: begin
                  dec_o.illegal   = 1'b1;
                  dec_o.reg_write = 1'b0;
               end
            endcase
         end
         OP_BEQ: begin
            dec_o.illegal = 1'b0;
            dec_o.ctrl    = ALU_SUB;
            dec_o.branch  = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: begin
            dec_o.illegal   = 1'b0;
            dec_o.alu_src   = 1'b1;
            dec_o.imm_sext  = 1'b1;
            dec_o.reg_write = 1'b1;
            unique case (op)
               OP_ADDI:  dec_o.ctrl = ALU_ADD;
               OP_SLTI:  dec_o.ctrl = ALU_SLT;
               OP_ANDI: begin
                  dec_o.ctrl     = ALU_AND;
                  dec_o.imm_sext = 1'b0;
               end
               OP_ORI: begin
                  dec_o.ctrl     = ALU_OR;
                  dec_o.imm_sext = 1'b0;
               end
               OP_SW: begin
                  dec_o.ctrl      = ALU_ADDU;
                  dec_o.reg_write = 1'b0;
               end
               default:  dec_o.ctrl = ALU_ADDU;  // addiu, lw
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_dec.sv
// alu_dec: ALU decoder with a 2-entry output skid FIFO.
//   clk, rst_n        : clock, async active-low reset
//   Instr / InValid   : instruction in; InReady (registered) accepts it
//   Flush             : drops buffered entries and any same-cycle input
//   ALUCtrl..Illegal  : decoded fields of the head entry (registered)
//   OutValid/OutReady : output handshake
module alu_dec
   import alu_dec_pkg::*;
#(
   parameter int W     = WORD_LEN,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [W-1:0]           Instr,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic                   Flush,
   output logic [ALUCTRL_LEN-1:0] ALUCtrl,
   output logic                   ALUSrc,
   output logic                   ImmSext,
   output logic                   RegWrite,
   output logic                   Branch,
   output logic                   Illegal,
   output logic                   OutValid,
   input  logic                   OutReady
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   dec_t       dec;
   dec_t       mem_q [DEPTH];
   dec_t       mem_d [DEPTH];
   dec_t       out_q, out_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       out_vld_q, in_rdy_q;
   logic       push, pop;

   alu_dec_core #(.W(W)) u_core (
      .instr_i (Instr),
      .dec_o   (dec)
   );

   always_comb begin
      push     = InValid & in_rdy_q & ~Flush;
      pop      = out_vld_q & OutReady & ~Flush;
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = dec;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
      if (Flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end
      // The output register tracks whatever will sit at the head next cycle,
      // including an entry written this cycle into an empty FIFO. When the
      // FIFO goes empty the last presented fields are kept.
      out_d = out_q;
      if (cnt_d != 2'd0) out_d = mem_d[rd_ptr_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= DEC_RST;
         out_q     <= DEC_RST;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         out_vld_q <= 1'b0;
         in_rdy_q  <= 1'b1;
      end else begin
         mem_q     <= mem_d;
         out_q     <= out_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         out_vld_q <= (cnt_d != 2'd0);
         in_rdy_q  <= (cnt_d < FULL);
      end
   end

   assign InReady  = in_rdy_q;
   assign OutValid = out_vld_q;
   assign ALUCtrl  = out_q.ctrl;
   assign ALUSrc   = out_q.alu_src;
   assign ImmSext  = out_q.imm_sext;
   assign RegWrite = out_q.reg_write;
   assign Branch   = out_q.branch;
   assign Illegal  = out_q.illegal;

endmodule
